// File: rtl/iodelay_tap_ctrl.sv
// IDELAYCTRL bring-up and per-lane IDELAYE2 tap loader: holds the delay
// controller in reset, waits for RDY, loads every lane with a default tap, then services tap requests.
//
// state          | meaning
// ---------------+----------------------------------------------------------
// ST_HOLD        | IDELAYCTRL RST asserted for hold_cycles_p cycles
// ST_WAIT_RDY    | RST released, waiting (bounded) for synchronized RDY
// ST_INIT_LOAD   | LD strobe on lane idx with the default tap
// ST_INIT_CHECK  | readback of lane idx against the default tap
// ST_IDLE        | calibrated, accepting tap-load requests
// ST_LOAD        | LD strobe on the captured lane with the captured tap
// ST_CHECK       | readback compare, done pulse

module iodelay_tap_ctrl #(
   parameter int lanes_p       = 5,
   parameter int tap_width_p   = 5,
   parameter int hold_cycles_p = 16,
   parameter int init_tap_p    = 0,
   parameter int rdy_timeout_p = 64,
   localparam int lane_w_p     = (lanes_p > 1) ? $clog2(lanes_p) : 1
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic                           idelayctrl_rdy_i,
   output logic                           idelayctrl_rst_o,
   output logic [lanes_p-1:0]             idelay_ld_o,
   output logic [tap_width_p-1:0]         idelay_cntvaluein_o,
   input  logic [lanes_p*tap_width_p-1:0] idelay_cntvalueout_i,
   input  logic                           v_i,
   input  logic [lane_w_p-1:0]            lane_i,
   input  logic [tap_width_p-1:0]         tap_i,
   output logic                           ready_o,
   output logic                           done_o,
   output logic                           err_o,
   output logic                           calibrated_o
);

   typedef enum logic [2:0] {
      ST_HOLD       = 3'd0,
      ST_WAIT_RDY   = 3'd1,
      ST_INIT_LOAD  = 3'd2,
      ST_INIT_CHECK = 3'd3,
      ST_IDLE       = 3'd4,
      ST_LOAD       = 3'd5,
      ST_CHECK      = 3'd6
   } state_e;

   localparam logic [7:0]             hold_last_lp = 8'(hold_cycles_p - 1);
   localparam logic [7:0]             tmo_last_lp  = 8'(rdy_timeout_p - 1);
   localparam logic [lane_w_p-1:0]    idx_last_lp  = lane_w_p'(lanes_p - 1);
   localparam logic [tap_width_p-1:0] init_tap_lp  = tap_width_p'(init_tap_p);

   state_e                   state_q, state_d;
   logic [7:0]               cnt_q, cnt_d;
   logic [lane_w_p-1:0]      idx_q, idx_d;
   logic [lane_w_p-1:0]      lane_q, lane_d;
   logic [tap_width_p-1:0]   cval_q, cval_d;
   logic                     err_q, err_d;
   logic                     cal_q, cal_d;
   logic                     rdy_meta_q, rdy_q;

   logic [lane_w_p-1:0]      sel;
   logic [tap_width_p-1:0]   readback;
   logic                     mismatch;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rdy_meta_q <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         rdy_meta_q <= idelayctrl_rdy_i;
         rdy_q      <= rdy_meta_q;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         idx_q   <= '0;
         lane_q  <= '0;
         cval_q  <= '0;
         err_q   <= 1'b0;
         cal_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         lane_q  <= lane_d;
         cval_q  <= cval_d;
         err_q   <= err_d;
         cal_q   <= cal_d;
      end
   end

   // cval_q doubles as the expected readback: it only changes when a load is entered.
   always_comb begin
      sel      = ((state_q == ST_LOAD) || (state_q == ST_CHECK)) ? lane_q : idx_q;
      readback = idelay_cntvalueout_i[int'(sel)*tap_width_p +: tap_width_p];
      mismatch = (readback != cval_q);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      idx_d   = idx_q;
      lane_d  = lane_q;
      cval_d  = cval_q;
      err_d   = 1'b0;
      cal_d   = cal_q;
      case (state_q)
         ST_HOLD: begin
            if (cnt_q == hold_last_lp) state_d = ST_WAIT_RDY;
            else                       cnt_d   = cnt_q + 8'd1;
         end
         ST_WAIT_RDY: begin
            if (rdy_q) begin
               state_d = ST_INIT_LOAD;
               idx_d   = '0;
               cval_d  = init_tap_lp;
            end else if (cnt_q == tmo_last_lp) begin
               state_d = ST_HOLD;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_INIT_LOAD: state_d = ST_INIT_CHECK;
         ST_INIT_CHECK: begin
            if (idx_q == idx_last_lp) begin
               state_d = ST_IDLE;
               cal_d   = 1'b1;
            end else begin
               state_d = ST_INIT_LOAD;
               idx_d   = idx_q + lane_w_p'(1);
            end
         end
         ST_IDLE: begin
            if (!rdy_q) begin
               state_d = ST_HOLD;
            end else if (v_i) begin
               if (int'(lane_i) < lanes_p) begin
                  state_d = ST_LOAD;
                  lane_d  = lane_i;
                  cval_d  = tap_i;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_LOAD:  state_d = rdy_q ? ST_CHECK : ST_HOLD;
         ST_CHECK: state_d = rdy_q ? ST_IDLE  : ST_HOLD;
         default:  state_d = ST_HOLD;
      endcase
      if (state_d == ST_HOLD) cal_d = 1'b0;
   end

   always_comb begin
      idelayctrl_rst_o    = (state_q == ST_HOLD);
      ready_o             = (state_q == ST_IDLE);
      idelay_cntvaluein_o = cval_q;
      calibrated_o        = cal_q;
      idelay_ld_o         = '0;
      if ((state_q == ST_LOAD) || (state_q == ST_INIT_LOAD))
         idelay_ld_o = lanes_p'(1) << sel;
      // A CHECK that sees RDY drop is aborted, so neither done nor err may escape.
      done_o = (state_q == ST_CHECK) && rdy_q;
      err_o  = err_q
             | ((state_q == ST_CHECK) && rdy_q && mismatch)
             | ((state_q == ST_INIT_CHECK) && mismatch);
   end

endmodule

// File: tb/tb_iodelay_tap_ctrl.sv
// Bench for iodelay_tap_ctrl: behavioural IDELAYE2 tap memory with optional
// readback corruption, random tap requests checked against per-request expectations.

module tb_iodelay_tap_ctrl;

   localparam int LANES = 5;
   localparam int TW    = 5;
   localparam int HOLD  = 16;
   localparam int TMO   = 64;
   localparam int INIT  = 0;

   logic              clk_i = 1'b0;
   logic              reset_n_i;
   logic              rdy_raw;
   logic              idelayctrl_rst_o;
   logic [LANES-1:0]  idelay_ld_o;
   logic [TW-1:0]     idelay_cntvaluein_o;
   logic [LANES*TW-1:0] idelay_cntvalueout_i;
   logic              v_i;
   logic [2:0]        lane_i;
   logic [TW-1:0]     tap_i;
   logic              ready_o, done_o, err_o, calibrated_o;

   logic [TW-1:0]     tap_mem [LANES];
   bit                corrupt;
   int                n_tests = 0;
   int                n_fail  = 0;

   iodelay_tap_ctrl #(
      .lanes_p(LANES), .tap_width_p(TW), .hold_cycles_p(HOLD),
      .init_tap_p(INIT), .rdy_timeout_p(TMO)
   ) dut (
      .clk_i(clk_i),
      .reset_n_i(reset_n_i),
      .idelayctrl_rdy_i(rdy_raw),
      .idelayctrl_rst_o(idelayctrl_rst_o),
      .idelay_ld_o(idelay_ld_o),
      .idelay_cntvaluein_o(idelay_cntvaluein_o),
      .idelay_cntvalueout_i(idelay_cntvalueout_i),
      .v_i(v_i),
      .lane_i(lane_i),
      .tap_i(tap_i),
      .ready_o(ready_o),
      .done_o(done_o),
      .err_o(err_o),
      .calibrated_o(calibrated_o)
   );

   always #5 clk_i = ~clk_i;

   // IDELAYE2 in VAR_LOAD: tap latches CNTVALUEIN on an LD edge; corrupt flips the LSB.
   always @(posedge clk_i) begin
      for (int n = 0; n < LANES; n++) begin
         if (!reset_n_i)          tap_mem[n] <= '0;
         else if (idelay_ld_o[n]) tap_mem[n] <= idelay_cntvaluein_o ^ TW'(corrupt);
      end
   end

   always_comb begin
      idelay_cntvalueout_i = '0;
      for (int n = 0; n < LANES; n++) idelay_cntvalueout_i[n*TW +: TW] = tap_mem[n];
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic check_reset_outputs(input string who);
      check_eq({who, "_rst"},   idelayctrl_rst_o, 1);
      check_eq({who, "_ld"},    idelay_ld_o, 0);
      check_eq({who, "_cval"},  idelay_cntvaluein_o, 0);
      check_eq({who, "_ready"}, ready_o, 0);
      check_eq({who, "_done"},  done_o, 0);
      check_eq({who, "_err"},   err_o, 0);
      check_eq({who, "_cal"},   calibrated_o, 0);
   endtask

   task automatic count_rst_high(output int n);
      n = 0;
      while (idelayctrl_rst_o && n < 300) begin
         n++;
         tick();
      end
   endtask

   // Starts at the first WAIT_RDY sample with synchronized RDY already high.
   task automatic wait_init();
      int pulses, last, cyc;
      bit saw_err;
      pulses = 0; last = 0; cyc = 0; saw_err = 0;
      while (!ready_o && cyc < 40) begin
         tick();
         cyc++;
         if (idelay_ld_o != 0) begin
            if (pulses == 0) check_eq("init_first_ld_lat", cyc, 1);
            else             check_eq("init_ld_gap", cyc - last, 2);
            check_eq("init_ld_lane", idelay_ld_o, 32'd1 << pulses);
            check_eq("init_cval", idelay_cntvaluein_o, INIT);
            last = cyc;
            pulses++;
         end
         if (err_o) saw_err = 1;
      end
      check_eq("init_pulses", pulses, LANES);
      check_eq("init_err", saw_err, 0);
      check_eq("init_ready", ready_o, 1);
      check_eq("init_cal", calibrated_o, 1);
   endtask

   initial begin
      int n, lane, tap, gap, exp_cval, k;
      bit bad;
      reset_n_i = 1'b0; rdy_raw = 1'b0; v_i = 1'b0; lane_i = '0; tap_i = '0; corrupt = 0;
      repeat (3) tick();
      check_reset_outputs("por");

      rdy_raw = 1'b1;
      tick();
      reset_n_i = 1'b1;
      count_rst_high(n);
      check_eq("hold_len", n, HOLD);
      wait_init();

      exp_cval = INIT;
      for (int i = 0; i < 60; i++) begin
         lane = $urandom_range(0, 7);
         tap  = $urandom_range(0, 31);
         bad  = ($urandom_range(0, 3) == 0);
         gap  = $urandom_range(0, 2);
         if (i == 0) begin lane = 2; tap = 13; bad = 0; end
         if (i == 1) begin lane = 2; tap = 13; bad = 1; end
         if (i == 2) begin lane = 6; tap = 13; bad = 0; end
         repeat (gap) tick();
         check_eq("req_ready", ready_o, 1);
         v_i = 1'b1; lane_i = lane[2:0]; tap_i = tap[TW-1:0]; corrupt = bad;
         tick();
         v_i = 1'b0;
         if (lane < LANES) begin
            exp_cval = tap;
            check_eq("req_ld", idelay_ld_o, 32'd1 << lane);
            check_eq("req_cval", idelay_cntvaluein_o, exp_cval);
            check_eq("req_early_done", done_o, 0);
            tick();
            corrupt = 0;
            check_eq("req_done", done_o, 1);
            check_eq("req_err", err_o, bad);
            check_eq("req_ld_clear", idelay_ld_o, 0);
            check_eq("req_cval_hold", idelay_cntvaluein_o, exp_cval);
            tick();
            check_eq("req_done_pulse", done_o, 0);
         end else begin
            corrupt = 0;
            check_eq("bad_lane_err", err_o, 1);
            check_eq("bad_lane_ld", idelay_ld_o, 0);
            check_eq("bad_lane_done", done_o, 0);
            check_eq("bad_lane_cval", idelay_cntvaluein_o, exp_cval);
            tick();
            check_eq("bad_lane_err_pulse", err_o, 0);
         end
      end

      // RDY drops early enough that the synchronized value is low while in LOAD.
      rdy_raw = 1'b0;
      tick();
      check_eq("abort_pre_ready", ready_o, 1);
      v_i = 1'b1; lane_i = 3'd1; tap_i = 5'd9;
      tick();
      v_i = 1'b0;
      check_eq("abort_ld", idelay_ld_o, 2);
      tick();
      check_eq("abort_rst", idelayctrl_rst_o, 1);
      check_eq("abort_cal", calibrated_o, 0);
      check_eq("abort_done", done_o, 0);
      check_eq("abort_err", err_o, 0);
      count_rst_high(n);
      check_eq("abort_hold_len", n, HOLD);

      k = 0;
      while (!err_o && k < 300) begin
         tick();
         k++;
      end
      check_eq("tmo_len", k, TMO);
      check_eq("tmo_rst", idelayctrl_rst_o, 1);
      rdy_raw = 1'b1;
      tick();
      check_eq("tmo_err_pulse", err_o, 0);
      count_rst_high(n);
      check_eq("tmo_hold_rest", n, HOLD - 1);
      wait_init();

      v_i = 1'b1; lane_i = 3'd3; tap_i = 5'd21;
      tick();
      v_i = 1'b0;
      check_eq("rst_load_ld", idelay_ld_o, 8);
      reset_n_i = 1'b0;
      #1;
      check_reset_outputs("rst_in_load");
      @(negedge clk_i);
      reset_n_i = 1'b1;
      count_rst_high(n);
      check_eq("rst_load_hold_len", n, HOLD);
      tick();
      check_eq("rst_init_ld", idelay_ld_o, 1);
      reset_n_i = 1'b0;
      #1;
      check_reset_outputs("rst_in_init");
      @(negedge clk_i);
      reset_n_i = 1'b1;
      count_rst_high(n);
      check_eq("rst_init_hold_len", n, HOLD);
      wait_init();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
